// File: rtl/aclk_time_entry.sv
// Time/alarm entry controller for the alarm clock core.
// Debounced buttons drive a BCD HH:MM edit FSM with load strobes.
module aclk_time_entry #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic [2:0] edit_state
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    T_HR  = 3'd1,
    T_MIN = 3'd2,
    A_HR  = 3'd3,
    A_MIN = 3'd4
  } state_e;

  // Button bit order: [2]=set, [1]=mode, [0]=inc
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    filt_q, filt_d;
  logic [2:0]    prev_q;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    ev;
  logic          ev_set, ev_mode, ev_inc;

  state_e      state_q, state_d;
  logic [1:0]  h1_q, h1_d, nh1;
  logic [3:0]  h0_q, h0_d, nh0;
  logic [3:0]  m1_q, m1_d, nm1;
  logic [3:0]  m0_q, m0_d, nm0;
  logic        ldt_q, ldt_d;
  logic        lda_q, lda_d;

  assign raw = {btn_set, btn_mode, btn_inc};

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES differing cycles
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]  = '0;
      filt_d[i] = filt_q[i];
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce counters, filtered levels and edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      filt_q <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end

  assign ev      = filt_q & ~prev_q;
  assign ev_set  = ev[2];
  assign ev_mode = ev[1] & ~ev[2];
  assign ev_inc  = ev[0] & ~ev[1] & ~ev[2];

  // BCD increment candidates for hours (00-23) and minutes (00-59)
  always_comb begin
    nh1 = h1_q;
    nh0 = h0_q;
    if (h1_q == 2'd2 && h0_q == 4'd3) begin
      nh1 = 2'd0;
      nh0 = 4'd0;
    end else if (h0_q == 4'd9) begin
      nh1 = h1_q + 2'd1;
      nh0 = 4'd0;
    end else begin
      nh0 = h0_q + 4'd1;
    end
    nm1 = m1_q;
    nm0 = m0_q;
    if (m0_q == 4'd9) begin
      nm0 = 4'd0;
      nm1 = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
    end else begin
      nm0 = m0_q + 4'd1;
    end
  end

  // Edit FSM next state, edit register and strobe requests
  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    ldt_d   = 1'b0;
    lda_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev_mode) begin
          state_d = T_HR;
          h1_d = '0; h0_d = '0;
          m1_d = '0; m0_d = '0;
        end
      end
      T_HR: begin
        if (ev_set) begin
          state_d = IDLE;
          ldt_d   = 1'b1;
        end else if (ev_mode) begin
          state_d = T_MIN;
        end else if (ev_inc) begin
          h1_d = nh1; h0_d = nh0;
        end
      end
      T_MIN: begin
        if (ev_set) begin
          state_d = IDLE;
          ldt_d   = 1'b1;
        end else if (ev_mode) begin
          state_d = A_HR;
          h1_d = '0; h0_d = '0;
          m1_d = '0; m0_d = '0;
        end else if (ev_inc) begin
          m1_d = nm1; m0_d = nm0;
        end
      end
      A_HR: begin
        if (ev_set) begin
          state_d = IDLE;
          lda_d   = 1'b1;
        end else if (ev_mode) begin
          state_d = A_MIN;
        end else if (ev_inc) begin
          h1_d = nh1; h0_d = nh0;
        end
      end
      A_MIN: begin
        if (ev_set) begin
          state_d = IDLE;
          lda_d   = 1'b1;
        end else if (ev_mode) begin
          state_d = IDLE;
        end else if (ev_inc) begin
          m1_d = nm1; m0_d = nm0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, edit register and registered load strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      h1_q    <= '0;
      h0_q    <= '0;
      m1_q    <= '0;
      m0_q    <= '0;
      ldt_q   <= 1'b0;
      lda_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      ldt_q   <= ldt_d;
      lda_q   <= lda_d;
    end
  end

  assign H_in1      = h1_q;
  assign H_in0      = h0_q;
  assign M_in1      = m1_q;
  assign M_in0      = m0_q;
  assign LD_time    = ldt_q;
  assign LD_alarm   = lda_q;
  assign edit_state = state_q;

endmodule

// File: tb/tb_aclk_time_entry.sv
// Testbench for aclk_time_entry: table vectors, corner
// sequences and random presses against a reference model.
module tb_aclk_time_entry;

  localparam int DEB  = 4;
  localparam int HOLD = DEB + 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_set;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm;
  logic [2:0] edit_state;

  aclk_time_entry #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_set   (btn_set),
    .H_in1     (H_in1),
    .H_in0     (H_in0),
    .M_in1     (M_in1),
    .M_in0     (M_in0),
    .LD_time   (LD_time),
    .LD_alarm  (LD_alarm),
    .edit_state(edit_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int lt_cnt = 0;
  int la_cnt = 0;
  int both_cnt = 0;

  // Strobe activity monitor (counts high cycles)
  always @(negedge clk) begin
    if (LD_time) lt_cnt++;
    if (LD_alarm) la_cnt++;
    if (LD_time && LD_alarm) both_cnt++;
  end

  // Reference model: state index, hours, minutes as integers
  int ms, mh, mmin, pl, pa;

  task automatic model_reset();
    ms = 0; mh = 0; mmin = 0;
  endtask

  task automatic model_step(input logic [2:0] b);
    pl = 0; pa = 0;
    if (b[2]) begin
      if (ms == 1 || ms == 2) pl = 1;
      else if (ms == 3 || ms == 4) pa = 1;
      ms = 0;
    end else if (b[1]) begin
      case (ms)
        0: begin ms = 1; mh = 0; mmin = 0; end
        1: ms = 2;
        2: begin ms = 3; mh = 0; mmin = 0; end
        3: ms = 4;
        default: ms = 0;
      endcase
    end else if (b[0]) begin
      if (ms == 1 || ms == 3) mh = (mh + 1) % 24;
      else if (ms == 2 || ms == 4) mmin = (mmin + 1) % 60;
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int dut_hh();
    return int'(H_in1) * 10 + int'(H_in0);
  endfunction

  function automatic int dut_mm();
    return int'(M_in1) * 10 + int'(M_in0);
  endfunction

  // Clean press: b = {set, mode, inc}
  task automatic press(input logic [2:0] b);
    @(negedge clk);
    {btn_set, btn_mode, btn_inc} = b;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    {btn_set, btn_mode, btn_inc} = 3'b000;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    model_step(b);
  endtask

  task automatic drive_inc(input logic lvl, input int cyc);
    @(negedge clk);
    btn_inc = lvl;
    repeat (cyc - 1) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] btn;
    int reps;
    int st;
    int hh;
    int mm;
    int lt;
    int la;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int l0, a0, r;
    logic [2:0] b;
    tbl.push_back('{3'b010,  1, 1,  0,  0, 0, 0});
    tbl.push_back('{3'b001, 23, 1, 23,  0, 0, 0});
    tbl.push_back('{3'b010,  1, 2, 23,  0, 0, 0});
    tbl.push_back('{3'b001, 59, 2, 23, 59, 0, 0});
    tbl.push_back('{3'b100,  1, 0, 23, 59, 1, 0});
    tbl.push_back('{3'b010,  1, 1,  0,  0, 0, 0});
    tbl.push_back('{3'b001,  9, 1,  9,  0, 0, 0});
    tbl.push_back('{3'b001,  1, 1, 10,  0, 0, 0});
    tbl.push_back('{3'b001, 13, 1, 23,  0, 0, 0});
    tbl.push_back('{3'b001,  1, 1,  0,  0, 0, 0});
    tbl.push_back('{3'b001,  5, 1,  5,  0, 0, 0});
    tbl.push_back('{3'b010,  1, 2,  5,  0, 0, 0});
    tbl.push_back('{3'b001, 60, 2,  5,  0, 0, 0});
    tbl.push_back('{3'b100,  1, 0,  5,  0, 1, 0});
    tbl.push_back('{3'b010,  3, 3,  0,  0, 0, 0});
    tbl.push_back('{3'b001,  7, 3,  7,  0, 0, 0});
    tbl.push_back('{3'b010,  1, 4,  7,  0, 0, 0});
    tbl.push_back('{3'b001, 30, 4,  7, 30, 0, 0});
    tbl.push_back('{3'b100,  1, 0,  7, 30, 0, 1});
    tbl.push_back('{3'b010,  5, 0,  0,  0, 0, 0});
    tbl.push_back('{3'b010,  2, 2,  0,  0, 0, 0});
    tbl.push_back('{3'b001,  3, 2,  0,  3, 0, 0});
    tbl.push_back('{3'b110,  1, 0,  0,  3, 1, 0});
    tbl.push_back('{3'b001,  2, 0,  0,  3, 0, 0});
    tbl.push_back('{3'b100,  1, 0,  0,  3, 0, 0});

    reset = 1'b1;
    {btn_set, btn_mode, btn_inc} = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(edit_state), 0);
    chk("reset_hh", dut_hh(), 0);
    chk("reset_mm", dut_mm(), 0);
    chk("reset_ld", int'({LD_time, LD_alarm}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      l0 = lt_cnt;
      a0 = la_cnt;
      for (int k = 0; k < tbl[i].reps; k++) press(tbl[i].btn);
      chk($sformatf("tbl%0d_state", i), int'(edit_state), tbl[i].st);
      chk($sformatf("tbl%0d_hh", i), dut_hh(), tbl[i].hh);
      chk($sformatf("tbl%0d_mm", i), dut_mm(), tbl[i].mm);
      chk($sformatf("tbl%0d_ldt", i), lt_cnt - l0, tbl[i].lt);
      chk($sformatf("tbl%0d_lda", i), la_cnt - a0, tbl[i].la);
    end

    // Debounce: short glitches then one bouncy press
    press(3'b010);
    for (int g = 1; g <= DEB - 1; g++) begin
      drive_inc(1'b1, g);
      drive_inc(1'b0, 12);
      chk($sformatf("glitch%0d_hh", g), dut_hh(), 0);
    end
    drive_inc(1'b1, 2);
    drive_inc(1'b0, 1);
    drive_inc(1'b1, 1);
    drive_inc(1'b0, 2);
    drive_inc(1'b1, 10);
    drive_inc(1'b0, 1);
    drive_inc(1'b1, 1);
    drive_inc(1'b0, 12);
    model_step(3'b001);
    chk("bouncy_hh", dut_hh(), 1);
    chk("bouncy_state", int'(edit_state), 1);

    // Reset mid-edit at 12:34 with a set event pending
    press(3'b100);
    press(3'b010);
    for (int k = 0; k < 12; k++) press(3'b001);
    press(3'b010);
    for (int k = 0; k < 34; k++) press(3'b001);
    chk("pre_rst_hh", dut_hh(), 12);
    chk("pre_rst_mm", dut_mm(), 34);
    chk("pre_rst_state", int'(edit_state), 2);
    l0 = lt_cnt;
    a0 = la_cnt;
    @(negedge clk);
    btn_set = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    #2;
    reset = 1'b1;
    btn_set = 1'b0;
    #1;
    chk("rst_async_state", int'(edit_state), 0);
    chk("rst_async_hh", dut_hh(), 0);
    chk("rst_async_mm", dut_mm(), 0);
    chk("rst_async_ld", int'({LD_time, LD_alarm}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    chk("rst_no_ldt", lt_cnt - l0, 0);
    chk("rst_no_lda", la_cnt - a0, 0);
    chk("rst_after_state", int'(edit_state), 0);

    // Random presses against the model
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) b = 3'b001;
      else if (r <= 7) b = 3'b010;
      else if (r == 8) b = 3'b100;
      else b = 3'($urandom_range(1, 7));
      l0 = lt_cnt;
      a0 = la_cnt;
      press(b);
      chk($sformatf("rnd%0d_state", n), int'(edit_state), ms);
      chk($sformatf("rnd%0d_hh", n), dut_hh(), mh);
      chk($sformatf("rnd%0d_mm", n), dut_mm(), mmin);
      chk($sformatf("rnd%0d_ldt", n), lt_cnt - l0, pl);
      chk($sformatf("rnd%0d_lda", n), la_cnt - a0, pa);
    end

    chk("ld_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
